seq_div32: RTL
==============

// Module: seq_div32
// PURPOSE
//  Multi-cycle restoring integer divider for the processor ALU; the inverse operation of the
//  carry/propagate sum path. Trial subtraction is done as rem + ~divisor + 1, one quotient bit
//  per clock. Sits beside the adder in the execute stage; the pipeline stalls while busy is high.
// PARAMETERS
//  WIDTH   32  operand/result width in bits, >= 2; normal-case latency is WIDTH+1 cycles
//  SIGNED  1   1: two's-complement operands, quotient truncates toward zero; 0: unsigned
// PORTS
//  clock            in   1      single clock; every register updates on the rising edge
//  reset            in   1      synchronous, active-low; sampled on the rising edge of clock
//  ctrl_div         in   1      start strobe; sampled only in IDLE or DONE
//  data_operandA    in   WIDTH  dividend; sampled on the accepting edge only
//  data_operandB    in   WIDTH  divisor; sampled on the accepting edge only
//  data_result      out  WIDTH  quotient
//  data_remainder   out  WIDTH  remainder; its sign follows the dividend (SIGNED=1)
//  data_exception   out  1      divide-by-zero or signed overflow
//  data_resultRDY   out  1      one-cycle pulse: result, remainder and exception are valid
//  busy             out  1      high in RUN and on the cycle the result is produced
// BEHAVIOUR
//  Reset: reset==0 at an edge forces state IDLE and clears every output and internal register.
//  Reset overrides all other inputs and aborts any operation in progress.
//  States:
//   IDLE: ctrl_div==1 -> latch |A|, |B|, signs and the divide-by-zero/overflow flags.
//         Next state is RUN, or EXC if a flag is set.
//   RUN:  count runs 0..WIDTH-1. Each cycle: rem = {rem[W-2:0], dvd[W-1]}, dvd <<= 1,
//         diff = rem + ~dvs + 1 (W+1 bits). If diff is non-negative, rem = diff and q[0] = 1.
//         After the count==WIDTH-1 cycle -> DONE.
//   DONE: negate the quotient if the signs differ; negate rem if the dividend was negative.
//         data_resultRDY=1 for this cycle only. Next IDLE, or RUN/EXC if ctrl_div==1.
//   EXC:  one cycle, data_resultRDY=1, data_exception=1, then IDLE (or a new start).
//  Latency: ctrl_div accepted at edge N -> data_resultRDY high after edge N+WIDTH+1 (33 cycles).
//  The EXC path completes after edge N+1.
//  Outputs are registered. Result, remainder and exception hold their values until the next
//  accepted start or reset. While RUN, data_result and data_remainder keep the previous
//  operation's values.
//  ctrl_div in RUN is ignored: no restart, no queueing.
//  ctrl_div in DONE/EXC is accepted on that edge (back-to-back operation).
//  Divide by zero (B==0): result = 0, remainder = A, exception = 1.
//  SIGNED overflow (A == 1<<(W-1), B == all ones): result = A, remainder = 0, exception = 1.
//  |A| of the most-negative value is handled in W+1-bit arithmetic; no spurious exception.
//  data_exception is 0 for every normal completion.
//  busy is high from the edge after acceptance up to and including the data_resultRDY cycle.
// TESTING
//  T1 reset low 3 cycles mid-RUN -> state IDLE; result, remainder, exception, resultRDY and busy all 0.
//  T2 A=100, B=7, start -> resultRDY exactly 33 cycles later; result=14, remainder=2, exception=0.
//  T3 A=-100 (0xFFFFFF9C), B=7 -> result=-14 (0xFFFFFFF2), remainder=-2 (0xFFFFFFFE).
//  T4 A=5, B=0 -> resultRDY 1 cycle later; result=0, remainder=5, exception=1.
//  T5 A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, exception=1. Then A=0x80000000, B=1
//     -> result=0x80000000, exception=0.
//  T6 ctrl_div held high throughout: ops complete every 33 cycles with no lost or duplicated
//     resultRDY; re-strobe during RUN does not change the result.

Source files
------------

// File: rtl/seq_div32.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Signed operands are divided as magnitudes and fixed up on completion.
module seq_div32 #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE,
    S_EXC
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;
  logic             r_sa;
  logic             r_sb;
  logic             r_div0;

  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_remainder;
  logic             r_exc;
  logic             r_rdy;
  logic             r_busy;

  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic             w_div0;
  logic             w_ovf;
  logic             w_flag;
  logic             w_start;
  logic             w_finish;

  logic [WIDTH:0]   w_sh;
  logic [WIDTH+1:0] w_diff;
  logic             w_ge;

  // Operand decode for the accepting edge
  always_comb begin
    w_sa     = SIGNED & data_operandA[WIDTH-1];
    w_sb     = SIGNED & data_operandB[WIDTH-1];
    w_abs_a  = w_sa ? (~data_operandA + 1'b1) : data_operandA;
    w_abs_b  = w_sb ? (~data_operandB + 1'b1) : data_operandB;
    w_div0   = (data_operandB == '0);
    w_ovf    = SIGNED
             & (data_operandA == {1'b1, {(WIDTH-1){1'b0}}})
             & (data_operandB == {WIDTH{1'b1}});
    w_flag   = w_div0 | w_ovf;
    w_finish = (r_state == S_DONE) | (r_state == S_EXC);
    w_start  = ctrl_div & ((r_state == S_IDLE) | w_finish);
  end

  // Trial subtraction kept one bit wider so an unsigned divisor
  // with its top bit set never loses the shifted-out remainder bit.
  always_comb begin
    w_sh   = {r_rem, r_dvd[WIDTH-1]};
    w_diff = {1'b0, w_sh} + ~{2'b00, r_dvs} + 1'b1;
    w_ge   = ~w_diff[WIDTH+1];
  end

  // State register
  always_ff @(posedge clock) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (ctrl_div) w_next = w_flag ? S_EXC : S_RUN;
      end
      S_RUN: begin
        if (r_cnt == LAST) w_next = S_DONE;
      end
      S_DONE, S_EXC: begin
        if (ctrl_div) w_next = w_flag ? S_EXC : S_RUN;
        else          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration and registered results
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_cnt       <= '0;
      r_sa        <= 1'b0;
      r_sb        <= 1'b0;
      r_div0      <= 1'b0;
      r_result    <= '0;
      r_remainder <= '0;
      r_exc       <= 1'b0;
      r_rdy       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rdy  <= 1'b0;
      r_busy <= (w_next != S_IDLE) | w_finish;
      if (r_state == S_RUN) begin
        r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
        r_q   <= {r_q[WIDTH-2:0], w_ge};
        r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_sh[WIDTH-1:0];
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == S_DONE) begin
        r_result    <= (r_sa ^ r_sb) ? (~r_q + 1'b1) : r_q;
        r_remainder <= r_sa ? (~r_rem + 1'b1) : r_rem;
        r_exc       <= 1'b0;
        r_rdy       <= 1'b1;
      end
      if (r_state == S_EXC) begin
        r_result    <= r_div0 ? '0 : r_dvd;
        r_remainder <= r_div0 ? r_dvd : '0;
        r_exc       <= 1'b1;
        r_rdy       <= 1'b1;
      end
      if (w_start) begin
        r_dvd  <= w_flag ? data_operandA : w_abs_a;
        r_dvs  <= w_abs_b;
        r_sa   <= w_sa;
        r_sb   <= w_sb;
        r_div0 <= w_div0;
        r_rem  <= '0;
        r_q    <= '0;
        r_cnt  <= '0;
      end
    end
  end

  assign data_result    = r_result;
  assign data_remainder = r_remainder;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;
  assign busy           = r_busy;

endmodule
